// File: rtl/varredura_pkg.sv
// Shared definitions for the servo sweep sequencer: state encoding (also
// exported on db_estado) and sweep limits/direction constants.
package varredura_pkg;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        POSICIONA = 4'd1,
        MEDE      = 4'd2,
        ESPERA    = 4'd3,
        REGISTRA  = 4'd4,
        PROXIMA   = 4'd5
    } estado_t;

    localparam logic [2:0] POS_MIN  = 3'd0;
    localparam logic [2:0] POS_MAX  = 3'd7;
    localparam logic       SUBINDO  = 1'b0;
    localparam logic       DESCENDO = 1'b1;

endpackage

// File: rtl/contador_ciclos.sv
// Cycle counter with synchronous clear, count enable and an equality flag
// against a runtime limit; saturates at all-ones instead of wrapping.
module contador_ciclos #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               conta,
    input  logic [LARGURA-1:0] limite,
    output logic               atingiu
);

    logic [LARGURA-1:0] valor_q;
    logic [LARGURA-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (limpa) begin
            valor_d = '0;
        end else if (conta && (valor_q != '1)) begin
            valor_d = valor_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign atingiu = (valor_q == limite);

endmodule

// File: rtl/controle_varredura_servo.sv
// Servo sweep sequencer: settle, measure handshake, report, advance 0..7..0.
// Optional measurement timeout enabled by defining TIMEOUT_MEDIDA_EN.
module controle_varredura_servo
    import varredura_pkg::*;
#(
    parameter int T_ACOMODA    = 50000000,
    parameter int T_TIMEOUT    = 5000000,
    parameter int LARGURA_CONT = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_medida,
    output logic [2:0] posicao,
    output logic       medir,
    output logic       ponto_pronto,
    output logic       sentido,
    output logic       ativo,
    output logic       erro_timeout,
    output logic [3:0] db_estado
);

    localparam logic [LARGURA_CONT-1:0] LIM_ACOMODA = LARGURA_CONT'(T_ACOMODA - 1);
    localparam logic [LARGURA_CONT-1:0] LIM_TIMEOUT = LARGURA_CONT'(T_TIMEOUT - 1);

    estado_t estado_q, estado_d;
    logic [2:0] posicao_q, posicao_d;
    logic sentido_q, sentido_d;
    logic cont_limpa, cont_conta, cont_atingiu;
    logic [LARGURA_CONT-1:0] cont_limite;
`ifdef TIMEOUT_MEDIDA_EN
    logic erro_timeout_q, erro_timeout_d;
`endif

    contador_ciclos #(
        .LARGURA(LARGURA_CONT)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .limpa  (cont_limpa),
        .conta  (cont_conta),
        .limite (cont_limite),
        .atingiu(cont_atingiu)
    );

    always_comb begin
        estado_d    = estado_q;
        posicao_d   = posicao_q;
        sentido_d   = sentido_q;
        cont_limpa  = 1'b0;
        cont_conta  = 1'b0;
        cont_limite = LIM_ACOMODA;
`ifdef TIMEOUT_MEDIDA_EN
        erro_timeout_d = 1'b0;
`endif
        case (estado_q)
            INICIAL: begin
                if (ligar) begin
                    estado_d   = POSICIONA;
                    cont_limpa = 1'b1;
                end
            end
            POSICIONA: begin
                cont_conta = 1'b1;
                if (cont_atingiu) begin
                    estado_d = MEDE;
                end
            end
            MEDE: begin
                estado_d   = ESPERA;
                cont_limpa = 1'b1;
            end
            ESPERA: begin
                cont_conta  = 1'b1;
                cont_limite = LIM_TIMEOUT;
                // fim_medida takes priority over a timeout expiring in the same cycle
                if (fim_medida) begin
                    estado_d = REGISTRA;
                end
`ifdef TIMEOUT_MEDIDA_EN
                else if (cont_atingiu) begin
                    estado_d       = PROXIMA;
                    erro_timeout_d = 1'b1;
                end
`endif
            end
            REGISTRA: begin
                estado_d = PROXIMA;
            end
            PROXIMA: begin
                if (!ligar) begin
                    estado_d = INICIAL;
                end else begin
                    estado_d   = POSICIONA;
                    cont_limpa = 1'b1;
                    // Endpoints reverse direction and step back, so each end is measured once per turn
                    if (sentido_q == SUBINDO) begin
                        if (posicao_q == POS_MAX) begin
                            sentido_d = DESCENDO;
                            posicao_d = POS_MAX - 3'd1;
                        end else begin
                            posicao_d = posicao_q + 3'd1;
                        end
                    end else begin
                        if (posicao_q == POS_MIN) begin
                            sentido_d = SUBINDO;
                            posicao_d = POS_MIN + 3'd1;
                        end else begin
                            posicao_d = posicao_q - 3'd1;
                        end
                    end
                end
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= INICIAL;
            posicao_q <= POS_MIN;
            sentido_q <= SUBINDO;
        end else begin
            estado_q  <= estado_d;
            posicao_q <= posicao_d;
            sentido_q <= sentido_d;
        end
    end

`ifdef TIMEOUT_MEDIDA_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            erro_timeout_q <= 1'b0;
        end else begin
            erro_timeout_q <= erro_timeout_d;
        end
    end
    assign erro_timeout = erro_timeout_q;
`else
    assign erro_timeout = 1'b0;
`endif

    assign posicao      = posicao_q;
    assign sentido      = sentido_q;
    assign medir        = (estado_q == MEDE);
    assign ponto_pronto = (estado_q == REGISTRA);
    assign ativo        = (estado_q != INICIAL);
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Self-checking bench for controle_varredura_servo (short settle/timeout values).
module tb_controle_varredura_servo;

    localparam int T_ACOMODA = 4;
    localparam int T_TIMEOUT = 20;

    logic       clock;
    logic       reset;
    logic       ligar;
    logic       fim_medida;
    logic [2:0] posicao;
    logic       medir;
    logic       ponto_pronto;
    logic       sentido;
    logic       ativo;
    logic       erro_timeout;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int idx    = 0;

    controle_varredura_servo #(
        .T_ACOMODA   (T_ACOMODA),
        .T_TIMEOUT   (T_TIMEOUT),
        .LARGURA_CONT(32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ligar       (ligar),
        .fim_medida  (fim_medida),
        .posicao     (posicao),
        .medir       (medir),
        .ponto_pronto(ponto_pronto),
        .sentido     (sentido),
        .ativo       (ativo),
        .erro_timeout(erro_timeout),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference sweep: point k of a run is at position tri_pos(k) of the
    // 14-step triangle wave 0..7..1; direction flag is the one held while measuring.
    function automatic logic [2:0] tri_pos(input int k);
        int p;
        p = k % 14;
        return (p <= 7) ? 3'(p) : 3'(14 - p);
    endfunction

    function automatic logic sent_esp(input int k);
        if (k == 0) return 1'b0;
        return (((k - 1) % 14) >= 7);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic espera_medir(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (medir === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    // fim_medida is high during the d-th cycle after the current one
    task automatic pulso_fim(input int d);
        repeat (d) step();
        fim_medida = 1'b1;
        step();
        fim_medida = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ligar = 1'b0; fim_medida = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
        checks++; if (posicao !== 3'd0) begin errors++; $display("FAIL reset_posicao got=%0d exp=0", posicao); end
        checks++; if (sentido !== 1'b0) begin errors++; $display("FAIL reset_sentido got=%0b exp=0", sentido); end
        checks++; if ({medir, ponto_pronto, erro_timeout, ativo} !== 4'b0000) begin
            errors++; $display("FAIL reset_saidas got=%b exp=0000", {medir, ponto_pronto, erro_timeout, ativo});
        end
    endtask

    task automatic test_start();
        int n; bit ok;
        ligar = 1'b1;
        step();
        checks++; if (ativo !== 1'b1) begin errors++; $display("FAIL start_ativo got=%b exp=1", ativo); end
        espera_medir(n, ok);
        checks++; if (!ok || (n + 1) != T_ACOMODA + 1) begin
            errors++; $display("FAIL start_latencia got=%0d ok=%0b exp=%0d", n + 1, ok, T_ACOMODA + 1);
        end
        checks++; if (posicao !== 3'd0) begin errors++; $display("FAIL start_posicao got=%0d exp=0", posicao); end
        step();
        checks++; if (medir !== 1'b0) begin errors++; $display("FAIL start_medir_unico got=%b exp=0", medir); end
        pulso_fim(2);
        checks++; if (ponto_pronto !== 1'b1 || posicao !== 3'd0) begin
            errors++; $display("FAIL start_ponto got=%b pos=%0d exp=1 pos=0", ponto_pronto, posicao);
        end
        idx = 1;
    endtask

    task automatic test_sweep();
        int n; bit ok;
        for (int i = 1; i < 16; i++) begin
            espera_medir(n, ok);
            checks++; if (!ok || n != T_ACOMODA + 2) begin
                errors++; $display("FAIL sweep_acomoda pt=%0d got=%0d ok=%0b exp=%0d", i, n, ok, T_ACOMODA + 2);
            end
            checks++; if (posicao !== tri_pos(idx)) begin
                errors++; $display("FAIL sweep_pos_medir pt=%0d got=%0d exp=%0d", i, posicao, tri_pos(idx));
            end
            pulso_fim($urandom_range(1, 5));
            checks++; if (ponto_pronto !== 1'b1) begin
                errors++; $display("FAIL sweep_ponto pt=%0d got=%b exp=1", i, ponto_pronto);
            end
            checks++; if (posicao !== tri_pos(idx) || sentido !== sent_esp(idx)) begin
                errors++; $display("FAIL sweep_pos_sent pt=%0d got=%0d/%b exp=%0d/%b",
                                   i, posicao, sentido, tri_pos(idx), sent_esp(idx));
            end
            idx++;
        end
    endtask

    task automatic test_pausa();
        int n; bit ok;
        for (int i = 0; i < 16 && tri_pos(idx) != 3'd3; i++) begin
            espera_medir(n, ok);
            pulso_fim($urandom_range(1, 4));
            checks++; if (ponto_pronto !== 1'b1 || posicao !== tri_pos(idx)) begin
                errors++; $display("FAIL pausa_pre got=%b pos=%0d exp=1 pos=%0d", ponto_pronto, posicao, tri_pos(idx));
            end
            idx++;
        end
        espera_medir(n, ok);
        step();
        ligar = 1'b0;
        pulso_fim(1);
        checks++; if (ponto_pronto !== 1'b1 || posicao !== 3'd3) begin
            errors++; $display("FAIL pausa_ponto got=%b pos=%0d exp=1 pos=3", ponto_pronto, posicao);
        end
        step(); step(); step(); step();
        checks++; if (db_estado !== 4'd0 || ativo !== 1'b0 || posicao !== 3'd3) begin
            errors++; $display("FAIL pausa_inicial got est=%0d ativo=%b pos=%0d exp est=0 ativo=0 pos=3",
                               db_estado, ativo, posicao);
        end
        ligar = 1'b1;
        step();
        espera_medir(n, ok);
        checks++; if (!ok || (n + 1) != T_ACOMODA + 1 || posicao !== 3'd3) begin
            errors++; $display("FAIL pausa_retoma got lat=%0d pos=%0d exp lat=%0d pos=3", n + 1, posicao, T_ACOMODA + 1);
        end
        pulso_fim($urandom_range(1, 5));
        checks++; if (ponto_pronto !== 1'b1 || posicao !== 3'd3) begin
            errors++; $display("FAIL pausa_ponto2 got=%b pos=%0d exp=1 pos=3", ponto_pronto, posicao);
        end
        idx++;
    endtask

    task automatic test_ignora_fim();
        int n; bit ok;
        step(); step();
        fim_medida = 1'b1;
        step();
        fim_medida = 1'b0;
        espera_medir(n, ok);
        fim_medida = 1'b1;
        step();
        fim_medida = 1'b0;
        repeat (4) step();
        checks++; if (db_estado !== 4'd3 || ponto_pronto !== 1'b0) begin
            errors++; $display("FAIL ignora_fim got est=%0d ponto=%b exp est=3 ponto=0", db_estado, ponto_pronto);
        end
        pulso_fim(0);
        checks++; if (ponto_pronto !== 1'b1 || posicao !== tri_pos(idx)) begin
            errors++; $display("FAIL ignora_ponto got=%b pos=%0d exp=1 pos=%0d", ponto_pronto, posicao, tri_pos(idx));
        end
        idx++;
    endtask

    task automatic test_reset_meio();
        int n; bit ok;
        for (int i = 0; i < 16 && !(tri_pos(idx) == 3'd5 && sent_esp(idx) == 1'b1); i++) begin
            espera_medir(n, ok);
            pulso_fim($urandom_range(1, 4));
            checks++; if (ponto_pronto !== 1'b1 || posicao !== tri_pos(idx)) begin
                errors++; $display("FAIL rstm_pre got=%b pos=%0d exp=1 pos=%0d", ponto_pronto, posicao, tri_pos(idx));
            end
            idx++;
        end
        espera_medir(n, ok);
        step();
        checks++; if (db_estado !== 4'd3 || posicao !== 3'd5 || sentido !== 1'b1) begin
            errors++; $display("FAIL rstm_pre_espera got est=%0d pos=%0d sent=%b exp est=3 pos=5 sent=1",
                               db_estado, posicao, sentido);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (db_estado !== 4'd0 || posicao !== 3'd0 || sentido !== 1'b0) begin
            errors++; $display("FAIL rstm_estado got est=%0d pos=%0d sent=%b exp est=0 pos=0 sent=0",
                               db_estado, posicao, sentido);
        end
        checks++; if ({medir, ponto_pronto, erro_timeout, ativo} !== 4'b0000) begin
            errors++; $display("FAIL rstm_saidas got=%b exp=0000", {medir, ponto_pronto, erro_timeout, ativo});
        end
        idx = 0;
    endtask

    task automatic test_timeout();
        int n; bit ok; bit viu_ponto;
`ifdef TIMEOUT_MEDIDA_EN
        for (int i = 0; i < 16 && tri_pos(idx) != 3'd2; i++) begin
            espera_medir(n, ok);
            pulso_fim($urandom_range(1, 4));
            idx++;
        end
        espera_medir(n, ok);
        n = 0; viu_ponto = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (ponto_pronto === 1'b1) viu_ponto = 1'b1;
            if (erro_timeout === 1'b1) break;
        end
        checks++; if (erro_timeout !== 1'b1 || n != T_TIMEOUT + 1) begin
            errors++; $display("FAIL timeout_latencia got=%0d erro=%b exp=%0d", n, erro_timeout, T_TIMEOUT + 1);
        end
        checks++; if (viu_ponto !== 1'b0) begin errors++; $display("FAIL timeout_sem_ponto got=1 exp=0"); end
        step();
        checks++; if (erro_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulso got=1 exp=0"); end
        idx++;
        espera_medir(n, ok);
        checks++; if (posicao !== 3'd3) begin errors++; $display("FAIL timeout_prox got=%0d exp=3", posicao); end
        pulso_fim(T_TIMEOUT);
        checks++; if (ponto_pronto !== 1'b1 || erro_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_empate got ponto=%b erro=%b exp ponto=1 erro=0", ponto_pronto, erro_timeout);
        end
        step();
        checks++; if (erro_timeout !== 1'b0) begin errors++; $display("FAIL timeout_empate_erro got=1 exp=0"); end
`else
        espera_medir(n, ok);
        viu_ponto = 1'b0;
        for (int i = 0; i < T_TIMEOUT + 10; i++) begin
            step();
            if (ponto_pronto === 1'b1 || erro_timeout === 1'b1) viu_ponto = 1'b1;
        end
        checks++; if (viu_ponto !== 1'b0 || db_estado !== 4'd3) begin
            errors++; $display("FAIL sem_timeout got est=%0d pulso=%b exp est=3 pulso=0", db_estado, viu_ponto);
        end
        pulso_fim(0);
        checks++; if (ponto_pronto !== 1'b1 || posicao !== tri_pos(idx)) begin
            errors++; $display("FAIL sem_timeout_ponto got=%b pos=%0d exp=1 pos=%0d", ponto_pronto, posicao, tri_pos(idx));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_start();
        test_sweep();
        test_pausa();
        test_ignora_fim();
        test_reset_meio();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
